adder: RTL and testbench

- Two's-complement adder for the equalizer datapath.
- Provides a combinational wrapping sum `c` for direct use in the same cycle.
- Also provides a registered, valid-qualified result with carry/overflow status and a sticky overflow flag, for downstream pipeline stages and error monitoring.

---
 rtl/adder.sv | 72 +++++++
 tb/tb_adder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Two's-complement adder: combinational wrapping sum c plus a registered,
// valid-qualified result with carry/overflow and sticky overflow. Optional ADDER_SATURATE_EN.
module adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic             sum_valid,
  output logic             carry_q,
  output logic             ovf_q,
  output logic             ovf_sticky
);
  localparam int MSB    = WIDTH - 1;
  localparam int STAGES = 1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } add_rsp_t;

  logic [WIDTH:0]    s;
  logic              carry;
  logic              ovf;
  logic [WIDTH-1:0]  sum_d;
  logic [STAGES:0]   vld_pipe;
  add_rsp_t          rsp_d;
  add_rsp_t          rsp_q;

  assign s     = {1'b0, a} + {1'b0, b};
  assign c     = s[MSB:0];
  assign carry = s[WIDTH];
  // Overflow only when both operands share a sign and the result sign differs.
  assign ovf   = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]);

`ifdef ADDER_SATURATE_EN
  // Direction of overflow follows the common operand sign.
  always_comb begin
    sum_d = s[MSB:0];
    if (ovf) sum_d = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign sum_d = s[MSB:0];
`endif

  assign rsp_d       = '{sum: sum_d, carry: carry, ovf: ovf};
  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q                <= '0;
      vld_pipe[STAGES:1]   <= '0;
      ovf_sticky           <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (in_valid) begin
        rsp_q <= rsp_d;
        if (ovf) ovf_sticky <= 1'b1;
      end
    end
  end

  assign sum_q     = rsp_q.sum;
  assign carry_q   = rsp_q.carry;
  assign ovf_q     = rsp_q.ovf;
  assign sum_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_adder.sv
// Bench for adder: directed literal checks plus randomized traffic compared
// every cycle against an arithmetic reference model.
module tb_adder;
  localparam int W = 16;

  logic         clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] c, sum_q;
  logic         sum_valid, carry_q, ovf_q, ovf_sticky;

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .in_valid(in_valid),
    .sum_q(sum_q), .sum_valid(sum_valid), .carry_q(carry_q),
    .ovf_q(ovf_q), .ovf_sticky(ovf_sticky)
  );

  initial begin
    #50;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] sum, output logic [W-1:0] reg_sum,
                                  output logic cy, output logic ov);
    int          sx = $signed(x);
    int          sy = $signed(y);
    int          ss = sx + sy;
    int unsigned us = 32'(x) + 32'(y);
    sum = us[W-1:0];
    cy  = us[W];
    ov  = (ss > 32767) || (ss < -32768);
`ifdef ADDER_SATURATE_EN
    reg_sum = (ss > 32767) ? 16'h7FFF : (ss < -32768) ? 16'h8000 : sum;
`else
    reg_sum = sum;
`endif
  endfunction

  // Expected registered state.
  logic [W-1:0] m_sum = '0;
  logic         m_vld = 1'b0, m_cy = 1'b0, m_ov = 1'b0, m_stk = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] s_w, s_r;
    logic cy, ov;
    if (rst) begin
      m_sum <= '0; m_vld <= 1'b0; m_cy <= 1'b0; m_ov <= 1'b0; m_stk <= 1'b0;
    end else begin
      ref_add(a, b, s_w, s_r, cy, ov);
      m_vld <= in_valid;
      if (in_valid) begin
        m_sum <= s_r; m_cy <= cy; m_ov <= ov;
        if (ov) m_stk <= 1'b1;
      end
    end
  end

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    logic [W-1:0] s_w, s_r;
    logic cy, ov;
    if (cmp_en) begin
      ref_add(a, b, s_w, s_r, cy, ov);
      chk("c",          32'(c),          32'(s_w));
      chk("sum_q",      32'(sum_q),      32'(m_sum));
      chk("sum_valid",  32'(sum_valid),  32'(m_vld));
      chk("carry_q",    32'(carry_q),    32'(m_cy));
      chk("ovf_q",      32'(ovf_q),      32'(m_ov));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_stk));
    end
  end

  task automatic edge_drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic v);
    @(posedge clk); #1;
    a = x; b = y; in_valid = v;
  endtask

  typedef struct { logic [W-1:0] x, y, exp; } comb_vec_t;
  comb_vec_t cv[6];

  initial begin
    logic [W-1:0] s_w, s_r;
    logic cy, ov;
`ifdef ADDER_SATURATE_EN
    logic [W-1:0] pos_sat = 16'h7FFF, neg_sat = 16'h8000;
`else
    logic [W-1:0] pos_sat = 16'h8000, neg_sat = 16'h7FFF;
`endif
    // Pin the model with hand-computed values.
    ref_add(16'h7FFF, 16'h0001, s_w, s_r, cy, ov);
    chk("model_posovf_sum", 32'(s_w), 32'h8000);
    chk("model_posovf_ovf", 32'(ov),  32'h1);
    ref_add(16'h8000, 16'hFFFF, s_w, s_r, cy, ov);
    chk("model_negovf_carry", 32'(cy), 32'h1);
    chk("model_negovf_sum",   32'(s_w), 32'h7FFF);

    #2 rst = 1'b1;
    #1;
    chk("rst_sum_q", 32'(sum_q), 0);
    chk("rst_valid", 32'(sum_valid), 0);
    chk("rst_carry", 32'(carry_q), 0);
    chk("rst_ovf",   32'(ovf_q), 0);
    chk("rst_stk",   32'(ovf_sticky), 0);

    cv[0] = '{16'd0, 16'd0, 16'd0};
    cv[1] = '{16'd10, 16'd12, 16'd22};
    cv[2] = '{16'd69, 16'd96, 16'd165};
    cv[3] = '{16'd1990, 16'd1921, 16'd3911};
    cv[4] = '{-16'sd5, 16'd5, 16'd0};
    cv[5] = '{-16'sd3731, 16'd8, 16'hF175};
    foreach (cv[i]) begin
      #4 a = cv[i].x; b = cv[i].y;
      #1 chk($sformatf("comb_%0d", i), 32'(c), 32'(cv[i].exp));
    end
    chk("comb_during_rst_valid", 32'(sum_valid), 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    edge_drive(16'd10, 16'd12, 1'b1);
    edge_drive(16'd0, 16'd0, 1'b0);
    #1 chk("reg_sum22", 32'(sum_q), 22);
    chk("reg_valid1", 32'(sum_valid), 1);
    edge_drive(16'd3, 16'd4, 1'b0);
    chk("hold_valid0", 32'(sum_valid), 0);
    chk("hold_sum22", 32'(sum_q), 22);

    edge_drive(16'h7FFF, 16'h0001, 1'b1);
    #1 chk("posovf_c", 32'(c), 32'h8000);
    edge_drive(16'd1, 16'd1, 1'b1);
    chk("posovf_sum",   32'(sum_q), 32'(pos_sat));
    chk("posovf_ovf",   32'(ovf_q), 1);
    chk("posovf_carry", 32'(carry_q), 0);
    chk("posovf_stk",   32'(ovf_sticky), 1);
    edge_drive(16'h8000, 16'hFFFF, 1'b1);
    chk("one_sum", 32'(sum_q), 2);
    chk("one_ovf", 32'(ovf_q), 0);
    chk("one_stk", 32'(ovf_sticky), 1);
    edge_drive(16'd0, 16'd0, 1'b0);
    chk("negovf_sum",   32'(sum_q), 32'(neg_sat));
    chk("negovf_carry", 32'(carry_q), 1);
    chk("negovf_ovf",   32'(ovf_q), 1);

    // Reset between edges while a result is valid.
    edge_drive(16'd100, 16'd200, 1'b1);
    @(posedge clk); #2;
    chk("mid_pre_valid", 32'(sum_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(sum_valid), 0);
    chk("mid_rst_sum",   32'(sum_q), 0);
    chk("mid_rst_stk",   32'(ovf_sticky), 0);
    chk("mid_rst_c",     32'(c), 300);
    #1 rst = 1'b0;
    edge_drive(16'd1000, 16'd234, 1'b0);
    @(posedge clk); #1;
    chk("post_rst_sum", 32'(sum_q), 300);

    // Randomized traffic with corner-biased operands and occasional reset.
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] x, y;
      @(posedge clk); #1;
      x = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000) : 16'($urandom);
      y = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2) - 1) : 16'($urandom);
      a = x; b = y; in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    @(posedge clk); #1;
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
